// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: pulses jogar, records the LED sequence, replays it on botoes.
// Optional macro ERRO_INJ_EN adds erro_en/erro_passo to corrupt one replayed step on purpose.
module jogador_automatico #(
  parameter int DEPTH     = 16,
  parameter int JOGAR_CYC = 5,
  parameter int HOLD_CYC  = 10,
  parameter int GAP_CYC   = 10,
  parameter int QUIET_CYC = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [3:0]                 leds,
  input  logic                       ganhou,
  input  logic                       perdeu,
`ifdef ERRO_INJ_EN
  input  logic                       erro_en,
  input  logic [$clog2(DEPTH)-1:0]   erro_passo,
`endif
  output logic                       jogar,
  output logic [3:0]                 botoes,
  output logic                       ativo,
  output logic                       terminou,
  output logic                       resultado,
  output logic [3:0]                 db_estado,
  output logic [$clog2(DEPTH+1)-1:0] db_passos
);

  localparam int NW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam int TL0  = (JOGAR_CYC > HOLD_CYC) ? JOGAR_CYC : HOLD_CYC;
  localparam int TLIM = (TL0 > GAP_CYC) ? TL0 : GAP_CYC;
  localparam int TW   = (TLIM > 1) ? $clog2(TLIM) : 1;

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    PULSO   = 4'h1,
    OBSERVA = 4'h2,
    PRESS   = 4'h3,
    GAP     = 4'h4,
    FIM     = 4'hF
  } estado_t;

  // Game interface is level-based, no valid/ready: every registered output holds for its own timed window.
  estado_t        state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [QW-1:0]  quiet_q, quiet_d;
  logic [NW-1:0]  n_q, n_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [3:0]     leds_prev_q;
  logic [3:0]     mem [DEPTH];
  logic           grava;
  logic           um_quente;
  logic [3:0]     passo_rd;
  logic           jogar_d, ativo_d, terminou_d, resultado_d;
  logic [3:0]     botoes_d;

  assign um_quente = (leds != 4'b0) && ((leds & (leds - 4'd1)) == 4'b0);
  assign db_estado = state_q;
  assign db_passos = n_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      timer_q     <= '0;
      quiet_q     <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      leds_prev_q <= '0;
      jogar       <= 1'b0;
      botoes      <= 4'b0;
      ativo       <= 1'b0;
      terminou    <= 1'b0;
      resultado   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      quiet_q     <= quiet_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      leds_prev_q <= leds;
      jogar       <= jogar_d;
      botoes      <= botoes_d;
      ativo       <= ativo_d;
      terminou    <= terminou_d;
      resultado   <= resultado_d;
    end
  end

  always_ff @(posedge clock) begin
    if (grava) mem[IW'(n_q)] <= leds;
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    quiet_d = quiet_q;
    n_d     = n_q;
    idx_d   = idx_q;
    grava   = 1'b0;
    case (state_q)
      OCIOSO: if (iniciar) state_d = PULSO;
      PULSO: begin
        if (timer_q == TW'(JOGAR_CYC - 1)) begin
          state_d = OBSERVA;
          n_d     = '0;
          quiet_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      OBSERVA: begin
        if (leds != 4'b0) begin
          quiet_d = '0;
          if (um_quente && (leds_prev_q == 4'b0) && (n_q < NW'(DEPTH))) begin
            grava = 1'b1;
            n_d   = n_q + NW'(1);
          end
        end else if (quiet_q == QW'(QUIET_CYC - 1)) begin
          // With nothing recorded the round has not been shown yet, so keep waiting.
          if (n_q != '0) begin
            state_d = PRESS;
            idx_d   = '0;
          end
        end else begin
          quiet_d = quiet_q + QW'(1);
        end
      end
      PRESS: begin
        if (timer_q == TW'(HOLD_CYC - 1)) state_d = GAP;
        else timer_d = timer_q + TW'(1);
      end
      GAP: begin
        if (timer_q == TW'(GAP_CYC - 1)) begin
          idx_d = idx_q + IW'(1);
          if (NW'(idx_q) + NW'(1) == n_q) begin
            state_d = OBSERVA;
            n_d     = '0;
            quiet_d = '0;
          end else begin
            state_d = PRESS;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FIM: if (iniciar) state_d = PULSO;
      default: state_d = OCIOSO;
    endcase
    if ((state_q != OCIOSO) && (state_q != FIM) && (ganhou || perdeu)) begin
      state_d = FIM;
      grava   = 1'b0;
      timer_d = '0;
      quiet_d = quiet_q;
      n_d     = n_q;
      idx_d   = idx_q;
    end
  end

  // Outputs are computed from the next state so they change on the edge that enters it.
  always_comb begin
    passo_rd = mem[idx_d];
`ifdef ERRO_INJ_EN
    if (erro_en && (idx_d == erro_passo)) passo_rd = {passo_rd[2:0], passo_rd[3]};
`endif
    jogar_d    = (state_d == PULSO);
    botoes_d   = (state_d == PRESS) ? passo_rd : 4'b0;
    ativo_d    = (state_d != OCIOSO) && (state_d != FIM);
    terminou_d = (state_d == FIM);
    if (state_d != FIM)      resultado_d = 1'b0;
    else if (state_q != FIM) resultado_d = ganhou;
    else                     resultado_d = resultado;
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: the bench plays the game side, showing LED sequences and checking the replay.
module tb_jogador_automatico;
  localparam int DEPTH     = 16;
  localparam int JOGAR_CYC = 5;
  localparam int HOLD_CYC  = 10;
  localparam int GAP_CYC   = 10;
  localparam int QUIET_CYC = 20;
  localparam int NW        = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset, iniciar, ganhou, perdeu;
  logic [3:0]    leds;
  logic          jogar, ativo, terminou, resultado;
  logic [3:0]    botoes, db_estado;
  logic [NW-1:0] db_passos;
`ifdef ERRO_INJ_EN
  logic                     erro_en;
  logic [$clog2(DEPTH)-1:0] erro_passo;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] show_q[$];
  int         on_q[$];
  int         off_q[$];

  always #5 clock = ~clock;

  jogador_automatico #(
    .DEPTH(DEPTH), .JOGAR_CYC(JOGAR_CYC), .HOLD_CYC(HOLD_CYC),
    .GAP_CYC(GAP_CYC), .QUIET_CYC(QUIET_CYC)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu),
`ifdef ERRO_INJ_EN
    .erro_en(erro_en), .erro_passo(erro_passo),
`endif
    .jogar(jogar), .botoes(botoes), .ativo(ativo), .terminou(terminou),
    .resultado(resultado), .db_estado(db_estado), .db_passos(db_passos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [3:0] v);
    return v inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  // Reference: the replay is the one-hot patterns shown, in order, capped at DEPTH.
  task automatic build_expected(input bit err_en, input int err_idx);
    logic [3:0] v;
    exp_q.delete();
    foreach (show_q[i])
      if (is_onehot(show_q[i]) && exp_q.size() < DEPTH) exp_q.push_back(show_q[i]);
    if (err_en && err_idx < exp_q.size()) begin
      v = exp_q[err_idx];
      exp_q[err_idx] = {v[2:0], v[3]};
    end
  endtask

  task automatic show_leds();
    foreach (show_q[i]) begin
      leds = show_q[i];
      repeat (on_q[i]) @(negedge clock);
      leds = 4'b0;
      if (i != show_q.size() - 1) repeat (off_q[i]) @(negedge clock);
    end
  endtask

  task automatic set_round(input logic [3:0] v, input int on_c, input int off_c);
    show_q.push_back(v);
    on_q.push_back(on_c);
    off_q.push_back(off_c);
  endtask

  task automatic clear_round();
    show_q.delete();
    on_q.delete();
    off_q.delete();
  endtask

  task automatic watch_replay(input string nome);
    int cnt, hold, gap, n_exp;
    logic [3:0] e;
    n_exp = exp_q.size();
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (botoes == 4'b0 && cnt < 200);
    check({nome, "_quiet"}, cnt, QUIET_CYC);
    check({nome, "_passos"}, db_passos, n_exp);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({nome, "_botao"}, botoes, e);
      hold = 0;
      while (db_estado == 4'h3 && hold < 100) begin
        hold++;
        @(negedge clock);
      end
      check({nome, "_hold"}, hold, HOLD_CYC);
      gap = 0;
      while (db_estado == 4'h4 && gap < 100) begin
        if (botoes != 4'b0) check({nome, "_gap_botoes"}, botoes, 0);
        gap++;
        @(negedge clock);
      end
      check({nome, "_gap"}, gap, GAP_CYC);
    end
    check({nome, "_volta_observa"}, db_estado, 4'h2);
    check({nome, "_passos_zerados"}, db_passos, 0);
  endtask

  task automatic start_game(input string nome);
    int cnt;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    cnt = 0;
    while (jogar && cnt < 50) begin
      cnt++;
      @(negedge clock);
    end
    check({nome, "_jogar_len"}, cnt, JOGAR_CYC);
    check({nome, "_observa"}, db_estado, 4'h2);
    check({nome, "_ativo"}, ativo, 1);
  endtask

  task automatic wait_estado(input logic [3:0] e, input string tag);
    int cnt;
    cnt = 0;
    while (db_estado != e && cnt < 300) begin
      @(negedge clock);
      cnt++;
    end
    check(tag, db_estado, e);
  endtask

  task automatic random_round(input int k);
    int len;
    logic [3:0] v;
    len = $urandom_range(1, 6);
    clear_round();
    for (int i = 0; i < len; i++) begin
      v = 4'(1 << $urandom_range(0, 3));
      if (i > 0 && $urandom_range(0, 3) == 0) v = 4'($urandom_range(1, 15));
      set_round(v, $urandom_range(1, 8), $urandom_range(1, 15));
    end
    build_expected(1'b0, 0);
    show_leds();
    watch_replay($sformatf("rnd%0d", k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; leds = 4'b0; ganhou = 1'b0; perdeu = 1'b0;
`ifdef ERRO_INJ_EN
    erro_en = 1'b0; erro_passo = '0;
`endif
    repeat (3) @(negedge clock);
    check("rst_jogar", jogar, 0);
    check("rst_botoes", botoes, 0);
    check("rst_ativo", ativo, 0);
    check("rst_terminou", terminou, 0);
    check("rst_resultado", resultado, 0);
    check("rst_estado", db_estado, 0);
    check("rst_passos", db_passos, 0);
    reset = 1'b0;
    @(negedge clock);

    start_game("inicio");

    clear_round();
    set_round(4'b0001, 10, 10);
    set_round(4'b0010, 10, 10);
    set_round(4'b0100, 10, 10);
    build_expected(1'b0, 0);
    show_leds();
    watch_replay("tres");

    iniciar = 1'b1;
    repeat (2) @(negedge clock);
    check("iniciar_ativo_estado", db_estado, 4'h2);
    check("iniciar_ativo_jogar", jogar, 0);
    iniciar = 1'b0;

    clear_round();
    set_round(4'b0011, 5, 5);
    set_round(4'b0001, 5, 5);
    build_expected(1'b0, 0);
    show_leds();
    watch_replay("nao_onehot");

    clear_round();
    for (int i = 0; i < 17; i++) set_round(4'(1 << $urandom_range(0, 3)), 2, 2);
    build_expected(1'b0, 0);
    show_leds();
    watch_replay("satura");

    for (int k = 0; k < 5; k++) random_round(k);

    clear_round();
    set_round(4'b1000, 4, 4);
    build_expected(1'b0, 0);
    show_leds();
    wait_estado(4'h4, "espera_gap");
    ganhou = 1'b1;
    @(negedge clock);
    ganhou = 1'b0;
    check("ganhou_terminou", terminou, 1);
    check("ganhou_resultado", resultado, 1);
    check("ganhou_botoes", botoes, 0);
    check("ganhou_estado", db_estado, 4'hF);
    check("ganhou_ativo", ativo, 0);
    repeat (3) @(negedge clock);
    check("fim_mantem", resultado, 1);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("reinicia_estado", db_estado, 4'h1);
    check("reinicia_terminou", terminou, 0);
    check("reinicia_resultado", resultado, 0);
    check("reinicia_jogar", jogar, 1);
    wait_estado(4'h2, "reinicia_observa");

    clear_round();
    set_round(4'b0010, 3, 3);
    show_leds();
    wait_estado(4'h3, "espera_press");
    perdeu = 1'b1;
    @(negedge clock);
    perdeu = 1'b0;
    check("perdeu_terminou", terminou, 1);
    check("perdeu_resultado", resultado, 0);
    check("perdeu_botoes", botoes, 0);

    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    ganhou = 1'b1; perdeu = 1'b1;
    @(negedge clock);
    ganhou = 1'b0; perdeu = 1'b0;
    check("ambos_resultado", resultado, 1);
    check("ambos_jogar", jogar, 0);
    check("ambos_estado", db_estado, 4'hF);

    start_game("pre_reset");
    clear_round();
    set_round(4'b0100, 3, 3);
    show_leds();
    wait_estado(4'h3, "reset_press");
    check("reset_press_botoes", botoes, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("reset_async_botoes", botoes, 0);
    check("reset_async_ativo", ativo, 0);
    check("reset_async_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

`ifdef ERRO_INJ_EN
    start_game("erro");
    erro_en = 1'b1;
    erro_passo = 1;
    clear_round();
    set_round(4'b1000, 4, 4);
    set_round(4'b0010, 4, 4);
    build_expected(1'b1, 1);
    show_leds();
    watch_replay("erro_inj");
    perdeu = 1'b1;
    @(negedge clock);
    perdeu = 1'b0;
    erro_en = 1'b0;
    check("erro_resultado", resultado, 0);
    check("erro_terminou", terminou, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Synthesizable automatic player for the memory game top level. It is the player end of the game's jogar/botoes/leds interface.
- Starts a game by pulsing jogar, then watches the game's leds output and records each displayed step.
- Once the display has gone quiet, it replays the recorded steps on botoes with fixed hold and gap timing.
- Repeats round by round until the game reports ganhou or perdeu. Used for on-board self-test and bench-free regression of the game.

Parameters:
- DEPTH, 16: maximum number of recorded steps per round.
- JOGAR_CYC, 5: length of the jogar pulse, in clock cycles.
- HOLD_CYC, 10: cycles each replayed button is held.
- GAP_CYC, 10: cycles of botoes=0 after each replayed button.
- QUIET_CYC, 20: consecutive cycles of leds==0 that end the observation phase.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  level; 1 while in OCIOSO or FIM starts a new game
- leds  in  4  game LED output, watched for displayed steps
- ganhou  in  1  game won flag
- perdeu  in  1  game lost flag
- jogar  out  1  start pulse to the game
- botoes  out  4  one-hot button drive to the game
- ativo  out  1  1 in every state except OCIOSO and FIM
- terminou  out  1  1 in FIM
- resultado  out  1  in FIM: 1 = ganhou, 0 = perdeu
- db_estado  out  4  state code
- db_passos  out  $clog2(DEPTH+1)  number of steps recorded this round

Behaviour:
- Reset (asynchronous) forces state OCIOSO. All outputs are 0. Step count n, index idx, timers and leds_prev are cleared. Memory contents are don't-care.
- State codes: OCIOSO=0, PULSO=1, OBSERVA=2, PRESS=3, GAP=4, FIM=F.
- OCIOSO: iniciar=1 → PULSO. Timer is cleared.
- PULSO: jogar=1 for exactly JOGAR_CYC cycles, then → OBSERVA with n=0 and quiet=0.
- OBSERVA, recording: leds_prev is a registered copy of leds. A step is recorded when leds is one-hot and leds_prev==0: mem[n]←leds, n←n+1.
- OBSERVA, ignored inputs: non-one-hot nonzero leds values are ignored. Edges arriving with n==DEPTH are ignored; the count saturates.
- OBSERVA, quiet timer: leds!=0 clears quiet. leds==0 increments quiet, saturating.
- OBSERVA, exit: quiet reaches QUIET_CYC with n>0 → PRESS, idx=0. With n==0 there is no timeout; the block keeps observing.
- PRESS: botoes=mem[idx] for HOLD_CYC cycles, then → GAP. leds is not sampled during PRESS or GAP, since the game echoes button presses.
- GAP: botoes=0 for GAP_CYC cycles, then idx←idx+1.
  - If the new idx==n → OBSERVA, with n←0, quiet←0 and leds_prev←leds.
  - Otherwise → PRESS.
- End of game: in any state except OCIOSO and FIM, ganhou=1 or perdeu=1 has priority over every other transition.
  - Next state is FIM. resultado←ganhou, latched in that same cycle. botoes and jogar go to 0 in that cycle.
  - If ganhou and perdeu are both 1, resultado=1.
- FIM: holds terminou=1 and resultado. iniciar=1 → PULSO, which clears resultado and terminou.
- Output register timing: all outputs are registered. botoes, jogar and db_estado change on the clock edge that enters the corresponding state; there is no combinational path from inputs to outputs.
- Counter widths: idx and the timers are sized with $clog2 of their limit. Every timer counts 0..LIMIT-1 and transitions on LIMIT-1.
- iniciar while ativo=1 has no effect.

Optional Feature:
- Macro ERRO_INJ_EN adds two inputs:
  - erro_en (1 bit)
  - erro_passo ($clog2(DEPTH) bits)
- When erro_en=1 and idx==erro_passo in PRESS, botoes={mem[idx][2:0],mem[idx][3]} (rotated left, so it is still one-hot but wrong). This is used to force perdeu.
- Without the macro these ports do not exist and replay is always exact.

Test Plan:
- Reset mid-PRESS with botoes=4'b0100: asynchronous reset → botoes=0, ativo=0, db_estado=0 before the next clock edge.
- iniciar=1 for 1 cycle from OCIOSO → jogar=1 for exactly 5 cycles, then db_estado=2.
- leds shows 0001, 0010, 0100, each 10 cycles on and 10 off, then 20 quiet cycles → db_passos=3. botoes then drives 0001/0010/0100, each 10 cycles on and 10 off, and the block returns to OBSERVA.
- leds shows 0011 and then 0001 → only 0001 is recorded, db_passos=1. 17 valid steps → db_passos=16 and only 16 replays.
- ganhou=1 during GAP → next cycle terminou=1, resultado=1, botoes=0. iniciar=1 → db_estado=1 and terminou=0.
- With ERRO_INJ_EN, erro_en=1, erro_passo=1 and recorded steps 1000, 0010 → replay is 1000 then 0100. When the game asserts perdeu → resultado=0.
